// File: rtl/mips_pkg.sv
// Constants and types shared by the MIPS pipeline debug blocks.
// Holds the register-dump FSM state type and the range-clamp helper.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    REQ  = 2'd2,
    SEND = 2'd3
  } regdump_state_t;

  // Limit an inclusive upper index to the last implemented register.
  function automatic logic [REG_ADDR_W-1:0] clamp_hi(input logic [REG_ADDR_W-1:0] hi,
                                                     input int num_regs);
    if (int'(hi) >= num_regs) return REG_ADDR_W'(num_regs - 1);
    return hi;
  endfunction

endpackage

// File: rtl/regdump_cycle_ctr.sv
// Free-running 32-bit cycle counter with a stamp register that captures the
// current count when latch_i is high. Used only with REGDUMP_CYCLE_STAMP_EN.
module regdump_cycle_ctr (
  input  logic        clk,
  input  logic        reset,
  input  logic        latch_i,
  output logic [31:0] stamp_o
);

  logic [31:0] count_q;
  logic [31:0] stamp_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      stamp_q <= '0;
    end else begin
      count_q <= count_q + 32'd1;
      if (latch_i) stamp_q <= count_q;
    end
  end

  assign stamp_o = stamp_q;

endmodule

// File: rtl/regfile_dump.sv
// Debug reader that walks a register range through the register file's debug
// port and streams index/value beats over valid/ready. REGDUMP_CYCLE_STAMP_EN adds a header beat.
module regfile_dump #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = mips_pkg::DATA_W
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [mips_pkg::REG_ADDR_W-1:0] range_lo,
  input  logic [mips_pkg::REG_ADDR_W-1:0] range_hi,
  output logic [mips_pkg::REG_ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0]               rf_rd_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [mips_pkg::REG_ADDR_W-1:0] out_index,
  output logic [DATA_W-1:0]               out_data,
  output logic                            out_hdr,
  output logic                            out_last,
  output logic                            busy,
  output logic                            done
);
  import mips_pkg::*;

  regdump_state_t          state_q, state_d;
  logic [REG_ADDR_W-1:0]   idx_q, idx_d;
  logic [REG_ADDR_W-1:0]   hi_q, hi_d;
  logic [REG_ADDR_W-1:0]   out_index_q, out_index_d;
  logic [DATA_W-1:0]       out_data_q, out_data_d;
  logic                    out_last_q, out_last_d;
  logic                    done_q, done_d;
  logic [REG_ADDR_W-1:0]   hi_lat;

  assign hi_lat = clamp_hi(range_hi, NUM_REGS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      hi_q        <= '0;
      out_index_q <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hi_q        <= hi_d;
      out_index_q <= out_index_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hi_d        = hi_q;
    out_index_d = out_index_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d = range_lo;
          hi_d  = hi_lat;
`ifdef REGDUMP_CYCLE_STAMP_EN
          state_d     = HDR;
          out_index_d = '0;
          out_last_d  = (range_lo > hi_lat);
`else
          state_d = REQ;
`endif
        end
      end
`ifdef REGDUMP_CYCLE_STAMP_EN
      HDR: begin
        if (out_ready) begin
          state_d = out_last_q ? IDLE : REQ;
          done_d  = out_last_q;
        end
      end
`endif
      REQ: begin
        // idx only exceeds hi here when the latched range was empty.
        if (idx_q > hi_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          out_index_d = idx_q;
          out_data_d  = rf_rd_data;
          out_last_d  = (idx_q == hi_q);
          state_d     = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (out_last_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rf_rd_addr = idx_q;
  assign out_index  = out_index_q;
  assign out_last   = out_last_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign out_valid  = (state_q == SEND) || (state_q == HDR);

`ifdef REGDUMP_CYCLE_STAMP_EN
  logic [31:0] stamp;

  regdump_cycle_ctr u_ctr (
    .clk     (clk),
    .reset   (reset),
    .latch_i ((state_q == IDLE) && start),
    .stamp_o (stamp)
  );

  assign out_hdr  = (state_q == HDR);
  assign out_data = (state_q == HDR) ? DATA_W'(stamp) : out_data_q;
`else
  assign out_hdr  = 1'b0;
  assign out_data = out_data_q;
`endif

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: stimulus pushes expected beats, a
// negedge monitor pops and compares every accepted beat and tracks done.
module tb_regfile_dump;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  range_lo, range_hi;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        out_valid, out_ready;
  logic [4:0]  out_index;
  logic [31:0] out_data;
  logic        out_hdr, out_last, busy, done;

  logic [31:0] regs [32];

  typedef struct {
    logic        hdr;
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int beats    = 0;
  int t_start  = 0;
  int done_base = 0;

`ifdef REGDUMP_CYCLE_STAMP_EN
  localparam int HL = 1;
  int ctr = 0;
  always @(posedge clk or posedge reset) begin
    if (reset) ctr <= 0;
    else       ctr <= ctr + 1;
  end
`else
  localparam int HL = 0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rf_rd_data = regs[rf_rd_addr];

  regfile_dump dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .range_lo   (range_lo),
    .range_hi   (range_hi),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_index  (out_index),
    .out_data   (out_data),
    .out_hdr    (out_hdr),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push(input logic h, input logic [4:0] i, input logic [31:0] d, input logic l);
    beat_t b;
    b.hdr = h; b.idx = i; b.data = d; b.last = l;
    exp_q.push_back(b);
  endtask

  // Monitor: accepted beats against the scoreboard, stability while stalled.
  logic        stall_prev = 1'b0;
  logic [4:0]  held_idx;
  logic [31:0] held_data;
  logic        held_last;
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (stall_prev) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_index", out_index, held_idx);
        chk("stall_data", out_data, held_data);
        chk("stall_last", out_last, held_last);
      end
      if (out_valid && out_ready) begin
        beats++;
        $display("beat hdr=%0d idx=%0d data=%0h last=%0d", out_hdr, out_index, out_data, out_last);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got idx=%0d data=%0h required none", out_index, out_data);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_hdr", out_hdr, e.hdr);
          chk("beat_index", out_index, e.idx);
          chk("beat_data", out_data, e.data);
          chk("beat_last", out_last, e.last);
        end
      end
      stall_prev = out_valid && !out_ready;
      held_idx   = out_index;
      held_data  = out_data;
      held_last  = out_last;
    end
  end

  // Called at posedge+1; returns just after the edge that samples start.
  task automatic do_start(input logic [4:0] lo, input logic [4:0] hi, input int stamp);
`ifdef REGDUMP_CYCLE_STAMP_EN
    push(1'b1, 5'd0, (stamp < 0) ? 32'(ctr) : 32'(stamp), lo > hi);
`endif
    start = 1'b1; range_lo = lo; range_hi = hi;
    t_start = cyc;
    done_base = done_cnt;
    $display("start lo=%0d hi=%0d", lo, hi);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_lat);
    bit seen = 0;
    for (int i = 0; i < 200; i++) begin
      if (done_cnt != done_base) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL %s_timeout: got no done required done", name);
    end else begin
      chk({name, "_latency"}, 32'(done_cyc - t_start), 32'(exp_lat));
    end
  endtask

  task automatic wait_beat(input logic [4:0] idx, output bit found);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid && !out_hdr && out_index == idx) begin found = 1; break; end
      @(posedge clk); #1;
    end
    if (!found) begin
      n_checks++;
      $display("FAIL wait_beat_%0d: got no beat required beat", idx);
    end
  endtask

  initial begin
    int  b0;
    bit  f;
    reset = 1'b1; start = 1'b0; range_lo = '0; range_hi = '0; out_ready = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = 32'hA000_0000 + 32'(i);
    for (int i = 8; i < 16; i++) regs[i] = 32'(4 * (i - 7));

    repeat (3) @(posedge clk); #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_index", out_index, 5'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_addr", rf_rd_addr, 5'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Full 8..15 dump, ready held high.
    b0 = beats;
    for (int k = 8; k < 16; k++) push(1'b0, 5'(k), 32'(4 * (k - 7)), k == 15);
    do_start(5'd8, 5'd15, -1);
    wait_done("dump8_15", 17 + HL);
    chk("dump8_15_beats", 32'(beats - b0), 32'(8 + HL));
    @(posedge clk); #1;

    // Same dump with a 3-cycle stall on index 10.
    b0 = beats;
    for (int k = 8; k < 16; k++) push(1'b0, 5'(k), 32'(4 * (k - 7)), k == 15);
    do_start(5'd8, 5'd15, -1);
    wait_beat(5'd10, f);
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done("stall", 20 + HL);
    chk("stall_beats", 32'(beats - b0), 32'(8 + HL));
    @(posedge clk); #1;

    // Empty range.
    do_start(5'd5, 5'd3, -1);
    chk("empty_busy", busy, 1'b1);
    chk("empty_done_early", done, 1'b0);
    @(posedge clk); #1;
    chk("empty_busy_after", busy, 1'b0);
    chk("empty_done", done, 1'b1);
    wait_done("empty", 2);
    @(posedge clk); #1;

    // 30..31 with a second start during the first data beat.
    b0 = beats;
    push(1'b0, 5'd30, 32'hA000_001E, 1'b0);
    push(1'b0, 5'd31, 32'hA000_001F, 1'b1);
    do_start(5'd30, 5'd31, -1);
    wait_beat(5'd30, f);
    start = 1'b1; range_lo = 5'd0; range_hi = 5'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("top2", 5 + HL);
    chk("top2_beats", 32'(beats - b0), 32'(2 + HL));
    repeat (4) @(posedge clk); #1;
    chk("top2_idle", busy, 1'b0);
    chk("top2_queue", 32'(exp_q.size()), 32'd0);

    // Reset while presenting index 12.
    for (int k = 8; k < 16; k++) push(1'b0, 5'(k), 32'(4 * (k - 7)), k == 15);
    do_start(5'd8, 5'd15, -1);
    wait_beat(5'd12, f);
    reset = 1'b1;
    #1;
    exp_q.delete();
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_last", out_last, 1'b0);
    chk("mid_rst_hdr", out_hdr, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_index", out_index, 5'd0);
    chk("mid_rst_data", out_data, 32'd0);
    chk("mid_rst_addr", rf_rd_addr, 5'd0);
    repeat (3) @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("mid_rst_no_done", 32'(done_cnt), 32'(done_base));
    push(1'b0, 5'd8, 32'd4, 1'b1);
    do_start(5'd8, 5'd8, -1);
    wait_done("after_rst", 3 + HL);
    @(posedge clk); #1;

`ifdef REGDUMP_CYCLE_STAMP_EN
    // Header stamp: start sampled when the counter reads 14.
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (14) @(posedge clk); #1;
    push(1'b0, 5'd9, 32'd8, 1'b1);
    do_start(5'd9, 5'd9, 14);
    wait_done("stamp", 4);
    @(posedge clk); #1;
`endif

    chk("final_queue", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
